// File: rtl/spike_address_tx_if.sv
// Downstream spike bus: the address presented to the MAC units plus its valid/ready handshake.
// A transfer happens on a rising edge where source_valid and source_ready are both high.
interface spike_address_tx_if #(
    parameter int ADDR_BITS = 12
);
    logic [ADDR_BITS-1:0] source_address;
    logic                 source_valid;
    logic                 source_ready;

    modport master (
        output source_address,
        output source_valid,
        input  source_ready
    );

    modport slave (
        input  source_address,
        input  source_valid,
        output source_ready
    );
endinterface

// File: rtl/spike_address_tx.sv
// Buffers local spike addresses in a FIFO and serialises them onto the downstream spike bus.
// Define SPIKE_TX_GAP_EN to insert a one-cycle idle GAP after every accepted spike.
module spike_address_tx #(
    parameter int                   ADDR_BITS    = 12,
    parameter int                   FIFO_DEPTH   = 8,
    parameter logic [ADDR_BITS-1:0] IDLE_ADDRESS = {ADDR_BITS{1'b1}}
) (
    input  logic                 CLK_Spk,
    input  logic                 RST_n,
    input  logic                 spike_in,
    input  logic [ADDR_BITS-1:0] spike_neuron_address,
    input  logic                 timestep_done,
    spike_address_tx_if.master   src,
    output logic                 fifo_full,
    output logic                 overflow,
    output logic [7:0]           spike_count,
    output logic [1:0]           fsm_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr;
    logic [PTR_W:0]       rd_ptr;
    logic [7:0]           accepted;
    logic [7:0]           accepted_inc;
    logic                 fifo_empty;
    logic                 handshake;
    logic                 push;
    logic                 drop;

    // The presented entry keeps its FIFO slot until it is accepted, so occupancy
    // includes the spike in flight and the slot is released on the handshake.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign handshake  = (state == S_SEND) && src.source_ready;
    assign push       = spike_in && (!fifo_full || handshake);
    assign drop       = spike_in && fifo_full && !handshake;
    assign fsm_state  = state;

    assign accepted_inc = (handshake && (accepted != 8'hFF)) ? accepted + 8'd1 : accepted;

    always_ff @(posedge CLK_Spk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= spike_neuron_address;
        end
    end

    always_ff @(posedge CLK_Spk or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (handshake) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_Spk or negedge RST_n) begin
        if (!RST_n) begin
            state              <= S_IDLE;
            src.source_address <= IDLE_ADDRESS;
            src.source_valid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        src.source_address <= mem[rd_ptr[PTR_W-1:0]];
                        src.source_valid   <= 1'b1;
                        state              <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (src.source_ready) begin
                        src.source_address <= IDLE_ADDRESS;
                        src.source_valid   <= 1'b0;
`ifdef SPIKE_TX_GAP_EN
                        state              <= S_GAP;
`else
                        state              <= S_IDLE;
`endif
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state              <= S_IDLE;
                    src.source_address <= IDLE_ADDRESS;
                    src.source_valid   <= 1'b0;
                end
            endcase
        end
    end

    // A handshake on the timestep_done cycle belongs to the timestep being closed.
    always_ff @(posedge CLK_Spk or negedge RST_n) begin
        if (!RST_n) begin
            accepted    <= 8'd0;
            spike_count <= 8'd0;
        end else if (timestep_done) begin
            spike_count <= accepted_inc;
            accepted    <= 8'd0;
        end else begin
            accepted    <= accepted_inc;
        end
    end
endmodule

// File: tb/tb_spike_address_tx.sv
// Directed bench for spike_address_tx: latency, hold-until-ready, overflow, full push/pop,
// reset mid-send, timestep counting and saturation, with a scoreboard on the output bus.
module tb_spike_address_tx;
`ifdef SPIKE_TX_GAP_EN
    localparam int GAP_CYC = 1;
`else
    localparam int GAP_CYC = 0;
`endif
    localparam int PERIOD = 2 + GAP_CYC;
    localparam logic [11:0] IDLE_A = 12'hFFF;

    logic        clk;
    logic        rst_n;
    logic        spike_in;
    logic [11:0] spike_addr;
    logic        timestep_done;
    logic        fifo_full;
    logic        overflow;
    logic [7:0]  spike_count;
    logic [1:0]  fsm_state;

    logic [11:0] exp_q[$];
    int          n_checks;
    int          n_fail;
    int          hs_count;

    spike_address_tx_if #(.ADDR_BITS(12)) src ();

    spike_address_tx #(
        .ADDR_BITS(12),
        .FIFO_DEPTH(8),
        .IDLE_ADDRESS(12'hFFF)
    ) dut (
        .CLK_Spk             (clk),
        .RST_n               (rst_n),
        .spike_in            (spike_in),
        .spike_neuron_address(spike_addr),
        .timestep_done       (timestep_done),
        .src                 (src),
        .fifo_full           (fifo_full),
        .overflow            (overflow),
        .spike_count         (spike_count),
        .fsm_state           (fsm_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every accepted spike must match the oldest expected address
    always @(negedge clk) begin
        if (rst_n && src.source_valid && src.source_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_spike", {20'd0, src.source_address}, 32'hFFFF_FFFF);
            end else begin
                check("sb_address", {20'd0, src.source_address}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_spike(input logic [11:0] a, input bit kept);
        spike_in   = 1'b1;
        spike_addr = a;
        if (kept) exp_q.push_back(a);
        tick();
        spike_in = 1'b0;
    endtask

    task automatic pulse_td();
        timestep_done = 1'b1;
        tick();
        timestep_done = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!src.source_valid && n < 20) begin
            tick();
            n++;
        end
        check(tag, {31'd0, src.source_valid}, 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        src.source_ready = 1'b1;
        while ((exp_q.size() != 0 || src.source_valid) && n < 400) begin
            tick();
            n++;
        end
        check(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        int  hs0;
        bit  seen;
        n_checks = 0;
        n_fail   = 0;
        hs_count = 0;
        rst_n            = 1'b0;
        spike_in         = 1'b0;
        spike_addr       = 12'd0;
        timestep_done    = 1'b0;
        src.source_ready = 1'b0;
        repeat (3) tick();

        check("rst_address", {20'd0, src.source_address}, {20'd0, IDLE_A});
        check("rst_valid", {31'd0, src.source_valid}, 32'd0);
        check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_spike_count", {24'd0, spike_count}, 32'd0);
        check("rst_fsm_idle", {30'd0, fsm_state}, 32'd0);
        rst_n = 1'b1;
        tick();

        // sequence 0,1,2 with ready held high
        src.source_ready = 1'b1;
        drive_spike(12'd0, 1'b1);
        check("lat_cycle1_valid", {31'd0, src.source_valid}, 32'd0);
        drive_spike(12'd1, 1'b1);
        check("lat_cycle2_valid", {31'd0, src.source_valid}, 32'd1);
        check("lat_cycle2_addr", {20'd0, src.source_address}, 32'd0);
        drive_spike(12'd2, 1'b1);
        for (int k = 1; k <= 2 * PERIOD; k++) begin
            check("seq_valid", {31'd0, src.source_valid}, {31'd0, (k % PERIOD) == 0});
            check("seq_addr", {20'd0, src.source_address},
                  ((k % PERIOD) == 0) ? (k / PERIOD) : {20'd0, IDLE_A});
            tick();
        end
        drain("seq_drain");
        pulse_td();
        check("seq_spike_count", {24'd0, spike_count}, 32'd3);

        // hold address and valid while ready is low
        src.source_ready = 1'b0;
        hs0 = hs_count;
        drive_spike(12'd5, 1'b1);
        wait_valid("hold_wait_valid");
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", {31'd0, src.source_valid}, 32'd1);
            check("hold_addr", {20'd0, src.source_address}, 32'd5);
            tick();
        end
        check("hold_valid_5th", {31'd0, src.source_valid}, 32'd1);
        src.source_ready = 1'b1;
        tick();
        src.source_ready = 1'b0;
        check("hold_after_valid", {31'd0, src.source_valid}, 32'd0);
        check("hold_after_addr", {20'd0, src.source_address}, {20'd0, IDLE_A});
        check("hold_one_handshake", hs_count - hs0, 32'd1);
        pulse_td();
        check("hold_spike_count", {24'd0, spike_count}, 32'd1);

        // overflow: 10 pushes into a depth-8 FIFO with ready low
        for (int i = 0; i < 10; i++) begin
            if (i == 8) begin
                check("ovf_full_after_8", {31'd0, fifo_full}, 32'd1);
                check("ovf_not_yet", {31'd0, overflow}, 32'd0);
            end
            drive_spike(12'h100 + 12'(i), i < 8);
        end
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_full_held", {31'd0, fifo_full}, 32'd1);
        hs0 = hs_count;
        drain("ovf_drain");
        src.source_ready = 1'b0;
        check("ovf_delivered", hs_count - hs0, 32'd8);
        check("ovf_full_cleared", {31'd0, fifo_full}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // asynchronous reset mid-send with entries buffered
        for (int i = 0; i < 4; i++) drive_spike(12'h0A0 + 12'(i), 1'b1);
        wait_valid("rst_mid_wait_valid");
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_address", {20'd0, src.source_address}, {20'd0, IDLE_A});
        check("rst_mid_valid", {31'd0, src.source_valid}, 32'd0);
        check("rst_mid_fifo_full", {31'd0, fifo_full}, 32'd0);
        check("rst_mid_overflow", {31'd0, overflow}, 32'd0);
        check("rst_mid_spike_count", {24'd0, spike_count}, 32'd0);
        exp_q.delete();
        hs0 = hs_count;
        tick();
        tick();
        rst_n = 1'b1;
        src.source_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (src.source_valid) seen = 1'b1;
            tick();
        end
        check("rst_mid_no_emit", {31'd0, seen}, 32'd0);
        check("rst_mid_no_handshake", hs_count - hs0, 32'd0);
        src.source_ready = 1'b0;

        // simultaneous push and pop while full
        for (int i = 0; i < 8; i++) drive_spike(12'h200 + 12'(i), 1'b1);
        check("pp_full", {31'd0, fifo_full}, 32'd1);
        check("pp_valid", {31'd0, src.source_valid}, 32'd1);
        check("pp_head", {20'd0, src.source_address}, 32'h200);
        spike_in   = 1'b1;
        spike_addr = 12'h208;
        exp_q.push_back(12'h208);
        src.source_ready = 1'b1;
        tick();
        spike_in = 1'b0;
        src.source_ready = 1'b0;
        check("pp_still_full", {31'd0, fifo_full}, 32'd1);
        check("pp_no_overflow", {31'd0, overflow}, 32'd0);
        drain("pp_drain");
        src.source_ready = 1'b0;
        check("pp_overflow_final", {31'd0, overflow}, 32'd0);
        check("pp_empty", {31'd0, fifo_full}, 32'd0);
        pulse_td();
        check("pp_spike_count", {24'd0, spike_count}, 32'd9);

        // handshake on the timestep_done cycle
        drive_spike(12'h055, 1'b1);
        wait_valid("co_wait_valid");
        src.source_ready = 1'b1;
        timestep_done    = 1'b1;
        tick();
        src.source_ready = 1'b0;
        timestep_done    = 1'b0;
        check("co_spike_count", {24'd0, spike_count}, 32'd1);
        check("co_valid_low", {31'd0, src.source_valid}, 32'd0);
        pulse_td();
        check("co_restart_zero", {24'd0, spike_count}, 32'd0);

        // 300 accepted spikes in one timestep saturate the count
        src.source_ready = 1'b1;
        hs0 = hs_count;
        for (int i = 0; i < 300; i++) begin
            drive_spike(12'(i), 1'b1);
            tick();
            tick();
        end
        drain("sat_drain");
        check("sat_delivered", hs_count - hs0, 32'd300);
        pulse_td();
        check("sat_spike_count", {24'd0, spike_count}, 32'd255);
        check("sat_no_overflow", {31'd0, overflow}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spike_address_tx.md
SPIKE_ADDRESS_TX -- requirements
Module: spike_address_tx

Interface
REQ-001 Parameter ADDR_BITS, default 12, SHALL set the width of every neuron/source address.
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL set the number of spike address entries buffered, and SHALL be a power of two.
REQ-003 Parameter IDLE_ADDRESS, default 12'hFFF, SHALL be the address driven on source_address when no spike is presented.
REQ-004 CLK_Spk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 RST_n  input  1  SHALL be the reset: asynchronous and active-low.
REQ-006 spike_in  input  1  SHALL be the one-cycle strobe indicating that the local neuron fired.
REQ-007 spike_neuron_address  input  ADDR_BITS  SHALL be the firing neuron's address, qualified by spike_in.
REQ-008 timestep_done  input  1  SHALL be the one-cycle end-of-timestep pulse.
REQ-009 source_address  output  ADDR_BITS  SHALL be the address presented to downstream MAC units.
REQ-010 source_valid  output  1  SHALL indicate that source_address carries a spike.
REQ-011 source_ready  input  1  SHALL be the downstream acceptance of the presented spike.
REQ-012 fifo_full  output  1  SHALL be high while the buffer holds FIFO_DEPTH entries.
REQ-013 overflow  output  1  SHALL be a sticky flag indicating that at least one spike was dropped.
REQ-014 spike_count  output  8  SHALL hold the number of spikes accepted downstream during the previous timestep.

Function
REQ-015 The block SHALL push spike_neuron_address into the FIFO on any cycle where spike_in=1 and the FIFO is not full.
REQ-016 A spike arriving while the FIFO is full SHALL be dropped, and overflow SHALL be set on the next edge.
REQ-017 A simultaneous push and pop SHALL be legal at any occupancy, including full.
REQ-018 The FSM SHALL have the states IDLE, SEND and GAP.
REQ-019 In IDLE with the FIFO non-empty, the block SHALL pop the head entry, load it into source_address, assert source_valid the next cycle and enter SEND.
REQ-020 In SEND, source_address and source_valid SHALL be held stable until a cycle with source_ready=1.
REQ-021 On the accepting cycle, the block SHALL go to GAP and drive IDLE_ADDRESS with source_valid=0 for exactly one cycle, then return to IDLE.
REQ-022 The latency from spike_in, with the FIFO empty and the FSM in IDLE, to source_valid SHALL be 2 cycles.
REQ-023 The sustained throughput SHALL be one spike per 3 cycles when source_ready is held at 1.
REQ-024 The internal accepted counter SHALL increment on each SEND handshake and SHALL saturate at 255.
REQ-025 On timestep_done, spike_count SHALL load the accepted counter, and the counter SHALL clear.
REQ-026 If a handshake coincides with timestep_done, that handshake SHALL be included in the loaded spike_count, and the counter SHALL restart at 0.
REQ-027 timestep_done SHALL NOT flush the FIFO or abort SEND; buffered spikes carry into the next timestep.
REQ-028 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and full/empty SHALL be resolved by an extra pointer bit.
REQ-029 Outside SEND, source_address SHALL equal IDLE_ADDRESS.

Reset
REQ-030 Asserting RST_n low SHALL immediately set source_address=IDLE_ADDRESS, source_valid=0, fifo_full=0, overflow=0 and spike_count=0, and SHALL set the FSM to IDLE and the FIFO to empty.
REQ-031 A reset asserted mid-SEND SHALL discard the in-flight spike and all buffered spikes without a handshake.
REQ-032 overflow SHALL be cleared only by reset.

Configuration
REQ-033 With SPIKE_TX_GAP_EN defined, the GAP state SHALL be present as described in REQ-021.
REQ-034 Without SPIKE_TX_GAP_EN, SEND SHALL go directly to IDLE on handshake, and a non-empty FIFO SHALL be presented on the following cycle, giving a throughput of one spike per 2 cycles; REQ-029 still applies.

Verification
REQ-035 Push addresses 0, 1, 2 on consecutive cycles with source_ready=1 -> source_address sequence 0, FFF, 1, FFF, 2, with source_valid only on data cycles.
REQ-036 Push address 5 with source_ready=0 for 4 cycles, then 1 -> address 5 and valid held for 5 cycles, handshake once, spike_count=1 after the next timestep_done.
REQ-037 Push 10 spikes back-to-back with source_ready=0 and FIFO_DEPTH=8 -> fifo_full=1 after 8 pushes, overflow=1, and exactly 8 spikes delivered once ready rises.
REQ-038 Push and pop in the same cycle while full -> occupancy stays 8 and overflow stays 0.
REQ-039 Assert RST_n=0 mid-SEND with 3 entries buffered -> outputs return to reset values asynchronously, and no spikes are emitted after release.
REQ-040 Accept 300 spikes within one timestep -> spike_count=255 after timestep_done.
